// File: rtl/keypad_pkg.sv
// Shared types and helpers for the scanning keypad encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld
  } state_e;

  function automatic int unsigned code_width(input int unsigned rows, input int unsigned cols);
    return ($clog2(rows * cols) < 1) ? 1 : $clog2(rows * cols);
  endfunction

  // Default 4x3 phone layout: row-major index to printed legend.
  function automatic logic [3:0] code_to_digit(input logic [3:0] idx);
    logic [3:0] digit;
    case (idx)
      4'd9:    digit = 4'hA;
      4'd10:   digit = 4'h0;
      4'd11:   digit = 4'hB;
      default: digit = (idx <= 4'd8) ? idx + 4'd1 : 4'h0;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event stream: valid/ready handshake carrying the key index.
interface keypad_scanner_if #(
  parameter int unsigned CODE_W = 4
) ();
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_fifo.sv
// Small synchronous FIFO; push when full is accepted only alongside a pop.
module keypad_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobed keypad matrix scanner with press/release debounce and an event FIFO.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 3,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CODE_W    = code_width(ROWS, COLS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ROWS-1:0]     row_drive,
  input  logic [COLS-1:0]     col_sense,
  keypad_scanner_if.master    key_if,
  output logic                key_down,
  output logic                overflow,
  input  logic                clear_overflow
);
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DWELL_W = $clog2(SETTLE + 1);
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE + 1);

  state_e             r_state;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [DWELL_W-1:0] r_dwell;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_key_down;
  logic               r_overflow;

  logic [ROW_W-1:0]   w_row_next;
  logic [COL_W-1:0]   w_col_idx;
  logic               w_one_hot;
  logic               w_match;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [CODE_W-1:0]  w_code;
  logic [CODE_W-1:0]  w_head;

  assign row_drive  = ROWS'(1) << r_row;
  assign key_down   = r_key_down;
  assign overflow   = r_overflow;
  assign w_row_next = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
  assign w_one_hot  = (col_sense != '0) && ((col_sense & (col_sense - COLS'(1))) == '0);
  assign w_match    = (col_sense == (COLS'(1) << r_col));
  assign w_code     = CODE_W'(r_row) * CODE_W'(COLS) + CODE_W'(r_col);
  assign w_push     = (r_state == StDebounce) && w_match && (r_cnt == CNT_W'(DEBOUNCE - 1));
  assign w_pop      = !w_empty && key_if.key_ready;
  assign w_drop     = w_push && w_full && !w_pop;

  always_comb begin
    w_col_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_sense[c]) w_col_idx = COL_W'(c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StScan;
      r_row      <= '0;
      r_col      <= '0;
      r_dwell    <= '0;
      r_cnt      <= '0;
      r_key_down <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;

      unique case (r_state)
        StScan: begin
          if (r_dwell == DWELL_W'(SETTLE - 1)) begin
            r_dwell <= '0;
            if (w_one_hot) begin
              r_state <= StDebounce;
              r_col   <= w_col_idx;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_row <= w_row_next;
            end
          end else begin
            r_dwell <= r_dwell + DWELL_W'(1);
          end
        end
        StDebounce: begin
          if (!w_match) begin
            r_state <= StScan;
            r_row   <= w_row_next;
            r_cnt   <= '0;
          end else if (w_push) begin
            r_state    <= StHeld;
            r_key_down <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StHeld: begin
          if (col_sense[r_col]) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE - 1)) begin
            r_state    <= StScan;
            r_key_down <= 1'b0;
            r_row      <= w_row_next;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= StScan;
      endcase
    end
  end

  keypad_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_code),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign key_if.key_valid = !w_empty;
  assign key_if.key_code  = w_head;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: directed key presses on a modelled switch matrix.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 3;
  localparam int unsigned CODE_W = code_width(ROWS, COLS);

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [ROWS-1:0]        row_drive;
  logic [COLS-1:0]        col_sense;
  logic                   key_down;
  logic                   overflow;
  logic                   clear_overflow = 1'b0;
  logic [ROWS*COLS-1:0]   keys = '0;

  int                     compared = 0;
  int                     mismatched = 0;
  int                     pops = 0;
  logic [3:0]             last_code = '0;
  logic [CODE_W-1:0]      exp_q[$];

  keypad_scanner_if #(.CODE_W(CODE_W)) kif ();

  keypad_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SETTLE     (2),
    .DEBOUNCE   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .row_drive      (row_drive),
    .col_sense      (col_sense),
    .key_if         (kif),
    .key_down       (key_down),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key connects its row strobe to its column.
  always_comb begin
    col_sense = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_drive[r] && keys[r*COLS+c]) col_sense[c] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s got=timeout required=event", name);
  endtask

  // Monitor: every accepted head must match the scoreboard front.
  always begin
    @(negedge clk);
    #1;
    if (!reset && kif.key_valid && kif.key_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event got=%0d required=none", kif.key_code);
      end else begin
        check("event_code", 32'(kif.key_code), 32'(exp_q.pop_front()));
      end
      last_code = 4'(kif.key_code);
      pops++;
    end
  end

  task automatic wait_kd(input logic val);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (key_down == val) seen = 1;
    end
    if (!seen) timeout_fail("wait_key_down");
  endtask

  // Returns at the negedge of the first dwell cycle of row r.
  task automatic wait_row(input int r);
    logic [ROWS-1:0] prev;
    bit seen = 0;
    prev = row_drive;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (row_drive == ROWS'(1 << r) && prev != row_drive) seen = 1;
      prev = row_drive;
    end
    if (!seen) timeout_fail("wait_row");
  endtask

  task automatic press(input int code);
    keys[code] = 1'b1;
    wait_kd(1'b1);
    keys[code] = 1'b0;
    wait_kd(1'b0);
  endtask

  logic [ROWS-1:0] exp_rows [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                    4'b0100, 4'b1000, 4'b1000, 4'b0001};
  int bp_codes [5] = '{0, 4, 8, 10, 11};

  initial begin
    kif.key_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-cycle, then free-running row scan.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_row_drive", 32'(row_drive), 32'h1);
    check("rst_key_valid", 32'(kif.key_valid), 32'h0);
    check("rst_key_down", 32'(key_down), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_key_code", 32'(kif.key_code), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      check("scan_step", 32'(row_drive), 32'(exp_rows[i]));
    end

    // Clean press of key 5 (row 1, col 2) with consumer ready.
    kif.key_ready = 1'b1;
    exp_q.push_back(CODE_W'(5));
    begin
      int pops0;
      pops0 = pops;
      keys[5] = 1'b1;
      wait_kd(1'b1);
      repeat (30) @(negedge clk);
      check("held_key_down", 32'(key_down), 32'h1);
      keys[5] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("release_hold", 32'(key_down), 32'h1);
      end
      @(negedge clk);
      check("release_done", 32'(key_down), 32'h0);
      check("clean_event_count", 32'(pops - pops0), 32'h1);
      check("digit_of_5", 32'(code_to_digit(last_code)), 32'h6);
    end

    // Ghost: two columns on row 0 are ignored.
    wait_row(0);
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("ghost_advance", 32'(row_drive), 32'b0010);
    check("ghost_key_down", 32'(key_down), 32'h0);
    keys = '0;

    // Bounce: key 6 closed only for the two dwell cycles of row 2.
    wait_row(2);
    keys[6] = 1'b1;
    repeat (2) @(negedge clk);
    check("bounce_row_hold", 32'(row_drive), 32'b0100);
    keys[6] = 1'b0;
    @(negedge clk);
    check("bounce_advance", 32'(row_drive), 32'b1000);
    check("bounce_key_down", 32'(key_down), 32'h0);

    // Backpressure: four events fit, the fifth is dropped.
    kif.key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(CODE_W'(bp_codes[i]));
      press(bp_codes[i]);
      if (i == 3) check("no_overflow_yet", 32'(overflow), 32'h0);
    end
    check("overflow_set", 32'(overflow), 32'h1);
    check("full_key_valid", 32'(kif.key_valid), 32'h1);
    kif.key_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("drained_valid", 32'(kif.key_valid), 32'h0);
    check("drained_queue", 32'(exp_q.size()), 32'h0);
    check("overflow_sticky", 32'(overflow), 32'h1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    check("overflow_clear", 32'(overflow), 32'h0);

    // Reset while held with two events queued.
    kif.key_ready = 1'b0;
    exp_q.push_back(CODE_W'(1));
    press(1);
    exp_q.push_back(CODE_W'(3));
    keys[3] = 1'b1;
    wait_kd(1'b1);
    check("queued_valid", 32'(kif.key_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 32'(kif.key_valid), 32'h0);
    check("midrst_key_down", 32'(key_down), 32'h0);
    check("midrst_row", 32'(row_drive), 32'h1);
    exp_q.delete();
    keys = '0;
    @(negedge clk);
    reset = 1'b0;
    kif.key_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("no_stale_valid", 32'(kif.key_valid), 32'h0);
    check("final_queue", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised successor to the static keypad encoder.
- Actively scans a ROWS x COLS switch matrix: drives one row at a time and samples the column lines.
- Debounces press and release, encodes each confirmed press as a key index, and queues press events in a small FIFO.
- Consumers read events through a valid/ready handshake. Sits between the board switch matrix and any key-consuming datapath.

Parameters:
- ROWS, 4, number of driven row lines (>=1)
- COLS, 3, number of sensed column lines (>=1)
- SETTLE, 2, cycles each row is driven before its columns are sampled (>=1)
- DEBOUNCE, 4, consecutive stable samples required to confirm a press or a release (>=2)
- FIFO_DEPTH, 4, event queue entries (power of 2, >=2)
- Derived: CODE_W = max(1, clog2(ROWS*COLS))

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- row_drive  out  ROWS  one-hot row strobe, active-high
- col_sense  in  COLS  column inputs, active-high, already synchronous to clk
- key_valid  out  1  FIFO head holds an event
- key_code  out  CODE_W  head event index = row*COLS + col
- key_ready  in  1  consumer accepts head this cycle
- key_down  out  1  a debounced key is currently held
- overflow  out  1  sticky: a press was dropped because the FIFO was full
- clear_overflow  in  1  clears overflow

Behaviour:
- Reset values (asynchronous on reset=1):
  - row_drive = 1 (row 0); state SCAN; dwell and debounce counters 0.
  - FIFO empty; key_valid=0, key_code=0, key_down=0, overflow=0.
- SCAN state:
  - Row r is driven for SETTLE cycles; col_sense is sampled only on the final dwell cycle.
  - Exactly one column c set: latch candidate (r,c), stable_cnt=1, enter DEBOUNCE; row stays r.
  - Zero or more than one column set (ghost/multi-key): r <- (r+1) mod ROWS, dwell restarts. Row ROWS-1 wraps to row 0.
- DEBOUNCE state:
  - Row held at r. Each cycle col_sense is compared against onehot(c).
  - Match: stable_cnt++. When it reaches DEBOUNCE: push code into the FIFO, key_down=1, enter HELD.
  - Mismatch: return to SCAN with the row advanced; no event.
- HELD state:
  - Row held at r; other columns are ignored (no rollover).
  - Each cycle with col_sense[c]=0 increments rel_cnt; any cycle with col_sense[c]=1 resets rel_cnt to 0.
  - When rel_cnt reaches DEBOUNCE: key_down=0, enter SCAN with the row advanced. Release produces no event.
- Latency: the sample that enters DEBOUNCE occurs at cycle t. With a continuously stable press, key_valid is first high at cycle t+DEBOUNCE if the FIFO was empty.
- FIFO:
  - key_valid = !empty; key_code = head entry, combinational from storage.
  - Pop when key_valid && key_ready.
  - Push when full without a simultaneous pop: the event is dropped and overflow is set.
  - Push when full with a simultaneous pop: the event is accepted.
  - Push and pop on an empty FIFO: push is stored and the head is not popped, since key_valid was 0.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
- overflow: cleared by clear_overflow; a new overflow in the same cycle wins (stays 1).
- Reset mid-operation (any state, e.g. HELD): immediate return to reset values; queued events are discarded.
- key_code always lies in 0..ROWS*COLS-1.

Decomposition:
- Shared package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, HELD};
  - the CODE_W computation function;
  - function code_to_digit for the default 4x3 phone layout: indices 0-8 -> 1-9, 10 -> 0, 9 -> '*' (4'hA), 11 -> '#' (4'hB).
- One sub-module: keypad_fifo, a synchronous FIFO with push/pop/full/empty and data out, parametrised by width and depth. Scan FSM, counters and row driver stay in keypad_scanner.

Test Plan:
- Reset: assert reset mid-cycle -> row_drive=4'b0001, key_valid=0, key_down=0, overflow=0 immediately; after release, row_drive steps 0001->0010->0100->1000->0001 every 2 cycles.
- Clean press at row 1, col 2, held 30 cycles, key_ready=1 -> exactly one event, key_code=5; key_down high from push until 4 cycles after release; code_to_digit(5)=6.
- Bounce: col 0 on row 2 high for 2 cycles only -> no event, key_down stays 0, scan resumes at row 3.
- Ghost: row 0 with col_sense=3'b011 -> no event, scan advances to row 1.
- Backpressure: key_ready=0, five distinct presses (codes 0, 4, 8, 10, 11) -> FIFO holds 0, 4, 8, 10 in order, overflow=1 after the fifth press. Raise key_ready -> four pops in order, then key_valid=0. Pulse clear_overflow -> overflow=0.
- Reset during HELD with two events queued -> key_valid=0 and key_down=0 at once; after reset release, no stale events appear.
